// File: rtl/hazard_pkg.sv
// Shared encodings and the per-stage tracking entry for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_D_GRF       = 2'd0;
  localparam logic [1:0] FWD_D_M_CALC    = 2'd1;
  localparam logic [1:0] FWD_D_E_SETWORD = 2'd2;

  localparam logic [1:0] FWD_E_REG       = 2'd0;
  localparam logic [1:0] FWD_E_W_REGDATA = 2'd1;
  localparam logic [1:0] FWD_E_M_CALC    = 2'd2;

  localparam logic [1:0] FWD_M_REG       = 2'd0;
  localparam logic [1:0] FWD_M_W_REGDATA = 2'd1;

  localparam logic [1:0] TNEW_SETWORD = 2'd0;
  localparam logic [1:0] TNEW_ALU     = 2'd1;
  localparam logic [1:0] TNEW_LOAD    = 2'd2;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] tnew;
  } track_t;

  // Register 0 is hardwired, so a zero destination never matches anything.
  function automatic logic hit(input track_t x, input logic [4:0] s);
    return (x.wa != 5'd0) && (x.wa == s);
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide unit busy tracker: flags a start sitting in E, then counts down the unit latency.
module md_busy_cnt #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic start_div,
  output logic busy
);

  logic       md_start_e_q, md_start_e_d;
  logic       md_div_e_q,   md_div_e_d;
  logic [3:0] md_cnt_q,     md_cnt_d;

  always_comb begin
    md_start_e_d = start;
    md_div_e_d   = start & start_div;
    md_cnt_d     = md_cnt_q;
    // The latency count begins once the start instruction has moved past E.
    if (md_start_e_q) begin
      md_cnt_d = md_div_e_q ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_start_e_q <= 1'b0;
      md_div_e_q   <= 1'b0;
      md_cnt_q     <= 4'd0;
    end else begin
      md_start_e_q <= md_start_e_d;
      md_div_e_q   <= md_div_e_d;
      md_cnt_q     <= md_cnt_d;
    end
  end

  assign busy = md_start_e_q | (md_cnt_q != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for a five-stage pipeline using Tuse/Tnew tracking.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic [4:0] D_wa,
  input  logic [1:0] D_tnew,
  input  logic       D_md_use,
  input  logic       D_md_start,
  input  logic       D_md_div,
  output logic       stall,
  output logic [1:0] D_GRF_rs_ForwardSrc,
  output logic [1:0] D_GRF_rt_ForwardSrc,
  output logic [1:0] E_GRF_rs_ForwardSrc,
  output logic [1:0] E_GRF_rt_ForwardSrc,
  output logic [1:0] M_GRF_rt_ForwardSrc
);

  track_t e_q, e_d;
  track_t m_q, m_d;
  track_t w_q, w_d;
  logic   md_busy;
  logic   md_stall;

  function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse,
                                     input track_t e, input track_t m);
    return (tuse != TUSE_NONE) &&
           ((hit(e, s) && (e.tnew > tuse)) || (hit(m, s) && (m.tnew > tuse)));
  endfunction

  function automatic logic [1:0] d_fwd(input logic [4:0] s, input track_t e, input track_t m);
    if (hit(e, s) && (e.tnew == 2'd0))      return FWD_D_E_SETWORD;
    else if (hit(m, s) && (m.tnew == 2'd0)) return FWD_D_M_CALC;
    else                                    return FWD_D_GRF;
  endfunction

  function automatic logic [1:0] e_fwd(input logic [4:0] s, input track_t m, input track_t w);
    if (hit(m, s) && (m.tnew == 2'd0)) return FWD_E_M_CALC;
    else if (hit(w, s))                return FWD_E_W_REGDATA;
    else                               return FWD_E_REG;
  endfunction

  assign md_stall = D_md_use & md_busy;

  always_comb begin
    stall = src_stall(D_rs, D_rs_tuse, e_q, m_q) |
            src_stall(D_rt, D_rt_tuse, e_q, m_q) |
            md_stall;
    D_GRF_rs_ForwardSrc = d_fwd(D_rs, e_q, m_q);
    D_GRF_rt_ForwardSrc = d_fwd(D_rt, e_q, m_q);
    E_GRF_rs_ForwardSrc = e_fwd(e_q.rs, m_q, w_q);
    E_GRF_rt_ForwardSrc = e_fwd(e_q.rt, m_q, w_q);
    M_GRF_rt_ForwardSrc = hit(w_q, m_q.rt) ? FWD_M_W_REGDATA : FWD_M_REG;
  end

  // D enters E with its raw result class; later advances count it down.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs   = D_rs;
      e_d.rt   = D_rt;
      e_d.wa   = D_wa;
      e_d.tnew = D_tnew;
    end
    m_d      = e_q;
    m_d.tnew = tnew_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = tnew_dec(m_q.tnew);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy (
    .clk      (clk),
    .reset    (reset),
    .start    (D_md_start & ~stall),
    .start_div(D_md_div),
    .busy     (md_busy)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, the number of cycles the multiply unit is busy after a mult/multu leaves D.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the number of cycles the multiply unit is busy after a div/divu leaves D.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port D_rs, input, 5 bits: rs address of the instruction in D.
REQ-006 SHALL have port D_rt, input, 5 bits: rt address of the instruction in D.
REQ-007 SHALL have port D_rs_tuse, input, 2 bits: stages until rs is consumed (0=D, 1=E, 2=M, 3=unused).
REQ-008 SHALL have port D_rt_tuse, input, 2 bits: same encoding as D_rs_tuse, for rt.
REQ-009 SHALL have port D_wa, input, 5 bits: destination register of the D instruction (0 = no write).
REQ-010 SHALL have port D_tnew, input, 2 bits: result class (0=SetWord, valid in E; 1=ALU, valid in M; 2=load, valid in W).
REQ-011 SHALL have port D_md_use, input, 1 bit: the D instruction accesses the multiply unit or HI/LO.
REQ-012 SHALL have port D_md_start, input, 1 bit: the D instruction is mult/multu/div/divu.
REQ-013 SHALL have port D_md_div, input, 1 bit: the started operation is a divide.
REQ-014 SHALL have port stall, output, 1 bit: freeze F/D and bubble E.
REQ-015 SHALL have ports D_GRF_rs_ForwardSrc and D_GRF_rt_ForwardSrc, output, 2 bits each: 0 = GRF, 1 = M_CalcResult, 2 = E_SetWordResult.
REQ-016 SHALL have ports E_GRF_rs_ForwardSrc and E_GRF_rt_ForwardSrc, output, 2 bits each: 0 = register, 1 = W_RegData, 2 = M_CalcResult.
REQ-017 SHALL have port M_GRF_rt_ForwardSrc, output, 2 bits: 0 = register, 1 = W_RegData.

Function
REQ-018 SHALL hold tracking registers {rs, rt, wa, tnew} for E, M and W, advancing D->E->M->W every cycle.
REQ-019 On each advance, tnew SHALL decrement, saturating at 0.
REQ-020 When stall=1, the E tracking entry SHALL load zeros (bubble) while M and W still advance.
REQ-021 Let hit(X,s) = (wa_X != 0) and (wa_X == s).
REQ-022 stall SHALL equal: any(hit(E,s) and tnew_E > tuse_s) or any(hit(M,s) and tnew_M > tuse_s) for s in {rs, rt} with tuse != 3, or md_stall.
REQ-023 D forward SHALL be priority-encoded: 2 if hit(E) and tnew_E==0; else 1 if hit(M) and tnew_M==0; else 0.
REQ-024 E forward SHALL be: 2 if hit(M) and tnew_M==0; else 1 if hit(W); else 0, using the E-tracked rs/rt.
REQ-025 M_GRF_rt_ForwardSrc SHALL be 1 if hit(W) on the M-tracked rt, else 0.
REQ-026 Address 0 SHALL never forward or stall.
REQ-027 All stall/forward outputs SHALL be combinational from registered state and D inputs, with zero-cycle latency.
REQ-028 The multiply unit SHALL have a 4-bit busy counter md_cnt and a flag md_start_E marking that E holds a start instruction.
REQ-029 When D_md_start=1 and stall=0, md_start_E SHALL be set next cycle; in the cycle after that, md_cnt SHALL load MULT_CYCLES or DIV_CYCLES.
REQ-030 md_cnt SHALL decrement to 0 and hold there.
REQ-031 md_stall SHALL be D_md_use and (md_start_E or md_cnt != 0).
REQ-032 A new start SHALL never be accepted while the unit is busy, because md_stall blocks it.

Reset
REQ-033 While reset=1, all tracking registers, md_cnt and md_start_E SHALL clear on the next edge.
REQ-034 After that edge, stall=0 and all ForwardSrc=0 provided the D inputs give no conflict.
REQ-035 Reset asserted mid-divide SHALL abort the divide, with md_cnt=0 in the following cycle.

Structure
REQ-036 Package hazard_pkg SHALL hold the ForwardSrc encodings, the TNEW_*/TUSE_* constants and the tracking-entry struct.
REQ-037 Sub-module md_busy_cnt SHALL implement the counter plus md_start_E and output busy.

Verification
REQ-038 lw $1 then add $2,$1,$3: exactly 1 stall cycle; then E_GRF_rs_ForwardSrc=1 for add.
REQ-039 addu $4,... then beq $4,$5: 1 stall cycle, then D_GRF_rs_ForwardSrc=1; lui $4 then beq $4: 0 stall cycles, D_GRF_rs_ForwardSrc=2.
REQ-040 addu $0,$1,$2 then addu $3,$0,$0: no stall, all ForwardSrc=0.
REQ-041 lw $6 then sw $6,0($7): no stall; M_GRF_rt_ForwardSrc=1 while sw is in M.
REQ-042 div then mfhi: stall held exactly 1+DIV_CYCLES=11 cycles; mult then mflo: 6 cycles.
REQ-043 div followed by reset on cycle 3: md_cnt=0, stall=0 and mfhi proceeds without stall.
